calc_port_responder: RTL and testbench

Single-port responder for the calculator request/response protocol: captures a command, tag and two operands on the input side, computes the result and returns response, data and tag on the output side after a fixed latency. It is the device end of one calculator port, used as a reference responder for bench checking and as the building block for multi-port calculator assemblies. It tracks outstanding tags and drops requests that reuse a tag still in flight.

---
 rtl/calc_port_responder.sv | 127 ++++++++++++
 tb/tb_calc_port_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_port_responder.sv
// rtl/calc_port_responder.sv - calculator port responder: two-cycle request capture,
// fixed-latency response pipeline, outstanding-tag tracking with drop counter.
module calc_port_responder #(
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [3:0]  cmd_i,
  input  logic [31:0] data_in_i,
  input  logic [1:0]  tag_in_i,
  output logic [1:0]  resp_o,
  output logic [31:0] data_out_o,
  output logic [1:0]  tag_out_o,
  output logic [3:0]  busy_tags_o,
  output logic [7:0]  drop_count_o
);

  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_ERR = 2'd2;
  localparam logic [3:0] CMD_NOP  = 4'd0;
  localparam logic [3:0] CMD_ADD  = 4'd1;
  localparam logic [3:0] CMD_SUB  = 4'd2;
  localparam logic [3:0] CMD_SHL  = 4'd5;
  localparam logic [3:0] CMD_SHR  = 4'd6;

  typedef enum logic {S_IDLE, S_OP2} state_t;

  typedef struct packed {
    logic        valid;
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
  } stage_t;

  state_t                   state_q, state_d;
  logic [3:0]               cmd_q, cmd_d;
  logic [31:0]              op1_q, op1_d;
  logic [1:0]               tag_q, tag_d;
  logic [3:0]               busy_q, busy_d;
  logic [7:0]               drop_q, drop_d;
  stage_t [LATENCY-1:0]     pipe_q;
  stage_t                   push;
  logic [32:0]              sum;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    drop_d  = drop_q;
    push    = '0;
    sum     = {1'b0, op1_q} + {1'b0, data_in_i};

    // Release first so a command reusing the returning tag sees it as free.
    if (pipe_q[LATENCY-1].valid) begin
      busy_d[pipe_q[LATENCY-1].tag] = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_i != CMD_NOP) begin
          if (!busy_d[tag_in_i]) begin
            cmd_d            = cmd_i;
            op1_d            = data_in_i;
            tag_d            = tag_in_i;
            busy_d[tag_in_i] = 1'b1;
            state_d          = S_OP2;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      S_OP2: begin
        push.valid = 1'b1;
        push.tag   = tag_q;
        push.resp  = RESP_OK;
        case (cmd_q)
          CMD_ADD: begin
            if (sum[32]) push.resp = RESP_ERR;
            else         push.data = sum[31:0];
          end
          CMD_SUB: begin
            if (data_in_i > op1_q) push.resp = RESP_ERR;
            else                   push.data = op1_q - data_in_i;
          end
          CMD_SHL: push.data = op1_q << data_in_i[4:0];
          CMD_SHR: push.data = op1_q >> data_in_i[4:0];
          default: push.resp = RESP_ERR;
        endcase
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      op1_q   <= '0;
      tag_q   <= '0;
      busy_q  <= '0;
      drop_q  <= '0;
      pipe_q  <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      op1_q     <= op1_d;
      tag_q     <= tag_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
      pipe_q[0] <= push;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Idle stages hold all-zero fields, so the last stage drives outputs directly.
  assign resp_o       = pipe_q[LATENCY-1].resp;
  assign data_out_o   = pipe_q[LATENCY-1].data;
  assign tag_out_o    = pipe_q[LATENCY-1].tag;
  assign busy_tags_o  = busy_q;
  assign drop_count_o = drop_q;

endmodule

// File: tb/tb_calc_port_responder.sv
// tb/tb_calc_port_responder.sv - directed vector bench for calc_port_responder
// (LATENCY=3 main instance, LATENCY=8 instance for four-in-flight tag occupancy).
module tb_calc_port_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cmd;
  logic [31:0] data_in;
  logic [1:0]  tag_in;

  logic [1:0]  resp3, resp8;
  logic [31:0] data3, data8;
  logic [1:0]  tag3, tag8;
  logic [3:0]  busy3, busy8;
  logic [7:0]  drop3, drop8;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  calc_port_responder #(.LATENCY(3)) dut3 (
    .clk_i(clk), .reset_i(reset), .cmd_i(cmd), .data_in_i(data_in), .tag_in_i(tag_in),
    .resp_o(resp3), .data_out_o(data3), .tag_out_o(tag3), .busy_tags_o(busy3),
    .drop_count_o(drop3)
  );

  calc_port_responder #(.LATENCY(8)) dut8 (
    .clk_i(clk), .reset_i(reset), .cmd_i(cmd), .data_in_i(data_in), .tag_in_i(tag_in),
    .resp_o(resp8), .data_out_o(data8), .tag_out_o(tag8), .busy_tags_o(busy8),
    .drop_count_o(drop8)
  );

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  tag;
    logic [3:0]  junk_cmd;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [3:0] c, input logic [31:0] d, input logic [1:0] t);
    cmd     = c;
    data_in = d;
    tag_in  = t;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drv(4'd0, 32'd0, 2'd0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'd1,  32'd5,          32'd7,          2'd2, 4'd0, 2'd1, 32'd12};
    vecs[1]  = '{4'd1,  32'hFFFF_FFFF,  32'd1,          2'd0, 4'd1, 2'd2, 32'd0};
    vecs[2]  = '{4'd2,  32'd3,          32'd4,          2'd1, 4'd2, 2'd2, 32'd0};
    vecs[3]  = '{4'd2,  32'd4,          32'd3,          2'd3, 4'd5, 2'd1, 32'd1};
    vecs[4]  = '{4'd5,  32'h1,          32'h24,         2'd0, 4'd0, 2'd1, 32'h10};
    vecs[5]  = '{4'd6,  32'h8000_0000,  32'd31,         2'd1, 4'd6, 2'd1, 32'h1};
    vecs[6]  = '{4'd3,  32'd9,          32'd9,          2'd2, 4'd0, 2'd2, 32'd0};
    vecs[7]  = '{4'd1,  32'hFFFF_FFFE,  32'd1,          2'd3, 4'd1, 2'd1, 32'hFFFF_FFFF};
    vecs[8]  = '{4'd2,  32'd5,          32'd5,          2'd0, 4'd0, 2'd1, 32'd0};
    vecs[9]  = '{4'd15, 32'd1,          32'd2,          2'd1, 4'd3, 2'd2, 32'd0};
    vecs[10] = '{4'd5,  32'hF000_0001,  32'h20,         2'd2, 4'd0, 2'd1, 32'hF000_0001};

    reset = 1'b1;
    drv(4'd0, 32'd0, 2'd0);
    step();
    step();
    reset = 1'b0;
    chk("reset resp", {30'd0, resp3}, 32'd0);
    chk("reset data", data3, 32'd0);
    chk("reset tag", {30'd0, tag3}, 32'd0);
    chk("reset busy", {28'd0, busy3}, 32'd0);
    chk("reset drop", {24'd0, drop3}, 32'd0);
    chk("reset busy L8", {28'd0, busy8}, 32'd0);
    chk("reset drop L8", {24'd0, drop8}, 32'd0);

    // Single requests; a junk command during the operand cycle must be ignored.
    for (int i = 0; i < NV; i++) begin
      vec_t v;
      logic [3:0] bmask;
      v = vecs[i];
      bmask = 4'b0001 << v.tag;
      drv(v.cmd, v.op1, v.tag);
      chk($sformatf("v%0d resp N", i), {30'd0, resp3}, 32'd0);
      step();
      drv(v.junk_cmd, v.op2, v.tag ^ 2'd1);
      chk($sformatf("v%0d busy N+1", i), {28'd0, busy3}, {28'd0, bmask});
      step();
      drv(4'd0, 32'd0, 2'd0);
      chk($sformatf("v%0d resp N+2", i), {30'd0, resp3}, 32'd0);
      step();
      chk($sformatf("v%0d resp N+3", i), {30'd0, resp3}, 32'd0);
      chk($sformatf("v%0d data N+3", i), data3, 32'd0);
      step();
      chk($sformatf("v%0d resp", i), {30'd0, resp3}, {30'd0, v.exp_resp});
      chk($sformatf("v%0d data", i), data3, v.exp_data);
      chk($sformatf("v%0d tag", i), {30'd0, tag3}, {30'd0, v.tag});
      chk($sformatf("v%0d busy N+4", i), {28'd0, busy3}, {28'd0, bmask});
      step();
      chk($sformatf("v%0d resp N+5", i), {30'd0, resp3}, 32'd0);
      chk($sformatf("v%0d data N+5", i), data3, 32'd0);
      chk($sformatf("v%0d tag N+5", i), {30'd0, tag3}, 32'd0);
      chk($sformatf("v%0d busy N+5", i), {28'd0, busy3}, 32'd0);
    end
    chk("table drop", {24'd0, drop3}, 32'd0);

    // Four back-to-back requests, tags 0..3, on both latencies.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      logic [1:0]  er3, er8;
      logic [31:0] ed3, ed8;
      logic [1:0]  et3, et8;
      logic [3:0]  eb3, eb8;
      if (c < 8) begin
        if (c % 2 == 0) drv(4'd1, 32'(16 * (c / 2)), 2'(c / 2));
        else            drv(4'd0, 32'((c - 1) / 2 + 1), 2'd0);
      end else begin
        drv(4'd0, 32'd0, 2'd0);
      end
      er3 = '0; ed3 = '0; et3 = '0; eb3 = '0;
      er8 = '0; ed8 = '0; et8 = '0; eb8 = '0;
      for (int k = 0; k < 4; k++) begin
        if (c == 2 * k + 4) begin er3 = 2'd1; ed3 = 32'(17 * k + 1); et3 = 2'(k); end
        if (c == 2 * k + 9) begin er8 = 2'd1; ed8 = 32'(17 * k + 1); et8 = 2'(k); end
        if (c >= 2 * k + 1 && c <= 2 * k + 4) eb3[k] = 1'b1;
        if (c >= 2 * k + 1 && c <= 2 * k + 9) eb8[k] = 1'b1;
      end
      chk($sformatf("b2b c%0d resp", c), {30'd0, resp3}, {30'd0, er3});
      chk($sformatf("b2b c%0d data", c), data3, ed3);
      chk($sformatf("b2b c%0d tag", c), {30'd0, tag3}, {30'd0, et3});
      chk($sformatf("b2b c%0d busy", c), {28'd0, busy3}, {28'd0, eb3});
      chk($sformatf("b2b L8 c%0d resp", c), {30'd0, resp8}, {30'd0, er8});
      chk($sformatf("b2b L8 c%0d data", c), data8, ed8);
      chk($sformatf("b2b L8 c%0d tag", c), {30'd0, tag8}, {30'd0, et8});
      chk($sformatf("b2b L8 c%0d busy", c), {28'd0, busy8}, {28'd0, eb8});
      step();
    end

    // Drop on busy tag; the cycle after a drop accepts a new command.
    do_reset();
    drv(4'd1, 32'd1, 2'd0);    step();
    drv(4'd0, 32'd1, 2'd0);    step();
    drv(4'd1, 32'hAA, 2'd0);
    chk("drop before", {24'd0, drop3}, 32'd0);
    chk("drop busy c2", {28'd0, busy3}, 32'h1);
    step();
    drv(4'd2, 32'd9, 2'd1);
    chk("drop count", {24'd0, drop3}, 32'd1);
    chk("drop busy c3", {28'd0, busy3}, 32'h1);
    step();
    drv(4'd0, 32'd2, 2'd0);
    chk("drop c4 resp", {30'd0, resp3}, 32'd1);
    chk("drop c4 data", data3, 32'd2);
    chk("drop c4 busy", {28'd0, busy3}, 32'h3);
    step();
    drv(4'd0, 32'd0, 2'd0);
    chk("drop c5 busy", {28'd0, busy3}, 32'h2);
    step();
    chk("dropped no resp", {30'd0, resp3}, 32'd0);
    step();
    chk("after drop resp", {30'd0, resp3}, 32'd1);
    chk("after drop data", data3, 32'd7);
    chk("after drop tag", {30'd0, tag3}, 32'd1);
    step();
    chk("after drop busy", {28'd0, busy3}, 32'd0);

    // Reset while in OP2 with the pipeline occupied.
    drv(4'd1, 32'd10, 2'd0);
    chk("pre-reset drop", {24'd0, drop3}, 32'd1);
    step();
    drv(4'd0, 32'd20, 2'd0);   step();
    drv(4'd1, 32'd30, 2'd1);   step();
    drv(4'd0, 32'd40, 2'd0);
    reset = 1'b1;
    chk("pre-reset busy", {28'd0, busy3}, 32'h3);
    step();
    reset = 1'b0;
    drv(4'd0, 32'd0, 2'd0);
    chk("mid-reset busy", {28'd0, busy3}, 32'd0);
    chk("mid-reset drop", {24'd0, drop3}, 32'd0);
    for (int c = 0; c < 7; c++) begin
      chk($sformatf("mid-reset c%0d resp", c), {30'd0, resp3}, 32'd0);
      step();
    end

    // Tag reuse in its own response cycle is accepted.
    drv(4'd1, 32'd3, 2'd0);    step();
    drv(4'd0, 32'd4, 2'd0);    step();
    drv(4'd0, 32'd0, 2'd0);    step();
    step();
    drv(4'd5, 32'd1, 2'd0);
    chk("reuse c4 resp", {30'd0, resp3}, 32'd1);
    chk("reuse c4 data", data3, 32'd7);
    chk("reuse c4 tag", {30'd0, tag3}, 32'd0);
    step();
    drv(4'd0, 32'd3, 2'd0);
    chk("reuse busy", {28'd0, busy3}, 32'h1);
    chk("reuse drop", {24'd0, drop3}, 32'd0);
    step();
    drv(4'd0, 32'd0, 2'd0);    step();
    chk("reuse c7 resp", {30'd0, resp3}, 32'd0);
    step();
    chk("reuse c8 resp", {30'd0, resp3}, 32'd1);
    chk("reuse c8 data", data3, 32'd8);
    chk("reuse c8 tag", {30'd0, tag3}, 32'd0);
    step();
    chk("reuse c9 busy", {28'd0, busy3}, 32'd0);

    // Continuous tag-0 commands: two drops per four cycles until saturation.
    do_reset();
    drv(4'd1, 32'd0, 2'd0);
    for (int n = 0; n < 600; n++) begin
      if (n == 8)   chk("sat n8", {24'd0, drop3}, 32'd4);
      if (n == 510) chk("sat n510", {24'd0, drop3}, 32'd254);
      if (n == 512) chk("sat n512", {24'd0, drop3}, 32'd255);
      step();
    end
    chk("sat final", {24'd0, drop3}, 32'd255);
    drv(4'd0, 32'd0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
